// File: rtl/alu_ctrl_pkg.sv
// Shared types and constants for the ALU control FSM: state encoding, op codes,
// instruction field positions and the decoder result record.
package alu_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    DECODE    = 2'd1,
    EXECUTE   = 2'd2,
    WRITEBACK = 2'd3
  } state_t;

  localparam logic [3:0] OP_RTYPE = 4'h0;
  localparam logic [3:0] OP_ANDI  = 4'h1;
  localparam logic [3:0] OP_ORI   = 4'h2;
  localparam logic [3:0] OP_XORI  = 4'h3;
  localparam logic [3:0] OP_ADDI  = 4'h5;
  localparam logic [3:0] OP_SUBI  = 4'h9;
  localparam logic [3:0] OP_CMPI  = 4'hB;
  localparam logic [3:0] OP_MOVI  = 4'hD;

  // R-type ext code for compare: result only sets flags, never a register.
  localparam logic [3:0] EXT_CMP = 4'hB;

  localparam int OP_LSB    = 12;
  localparam int RDEST_LSB = 8;
  localparam int EXT_LSB   = 4;
  localparam int RSRC_LSB  = 0;

  typedef struct packed {
    logic [4:0]  control1;
    logic [4:0]  control2;
    logic        imm_control;
    logic [7:0]  opcode;
    logic [15:0] immediate;
    logic        no_write;
    logic        illegal;
  } decode_t;

  function automatic logic [3:0] field(input logic [15:0] word, input int lsb);
    return word[lsb +: 4];
  endfunction

endpackage

// File: rtl/alu_ctrl_fsm_if.sv
// Instruction handshake and datapath control bundle of the ALU control FSM.
// master = instruction source / datapath side, slave = the control FSM.
interface alu_ctrl_fsm_if #(
  parameter int NUM_REGS = 16
);
  logic [15:0]         instr;
  logic                instr_valid;
  logic                instr_ready;
  logic [NUM_REGS-1:0] enable;
  logic [4:0]          control1;
  logic [4:0]          control2;
  logic                imm_control;
  logic [7:0]          opcode;
  logic [15:0]         immediate;
  logic                buff_en;
  logic                busy;
  logic                illegal;

  modport master (
    output instr, instr_valid,
    input  instr_ready, enable, control1, control2, imm_control,
           opcode, immediate, buff_en, busy, illegal
  );

  modport slave (
    input  instr, instr_valid,
    output instr_ready, enable, control1, control2, imm_control,
           opcode, immediate, buff_en, busy, illegal
  );
endinterface

// File: rtl/alu_ctrl_decode.sv
// Combinational decode of the latched instruction word into operand selects,
// ALU opcode, extended immediate and the no-write / illegal flags.
module alu_ctrl_decode
  import alu_ctrl_pkg::*;
(
  input  logic [15:0] ir,
  output decode_t     dec
);

  logic [3:0] op;
  logic [3:0] rdest;
  logic [3:0] ext;
  logic [3:0] rsrc;
  logic [7:0] imm8;

  assign op    = field(ir, OP_LSB);
  assign rdest = field(ir, RDEST_LSB);
  assign ext   = field(ir, EXT_LSB);
  assign rsrc  = field(ir, RSRC_LSB);
  assign imm8  = {ext, rsrc};

  always_comb begin
    // NOTE: defaulting the whole record first means no path leaves a field unassigned, so no latch is inferred.
    dec          = '0;
    dec.control1 = {1'b0, rdest};
    dec.control2 = {1'b0, rsrc};
    case (op)
      OP_RTYPE: begin
        dec.opcode   = {op, ext};
        dec.no_write = (ext == EXT_CMP);
      end
      OP_ANDI, OP_ORI, OP_XORI: begin
        dec.imm_control = 1'b1;
        dec.opcode      = {op, 4'h0};
        dec.immediate   = {8'h00, imm8};
      end
      OP_ADDI, OP_SUBI, OP_CMPI, OP_MOVI: begin
        dec.imm_control = 1'b1;
        dec.opcode      = {op, 4'h0};
        dec.immediate   = {{8{imm8[7]}}, imm8};
        dec.no_write    = (op == OP_CMPI);
      end
      default: begin
        dec.illegal  = 1'b1;
        dec.no_write = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/alu_ctrl_fsm.sv
// Four-state instruction sequencer driving the ALU datapath controls.
// Define ALU_CTRL_PIPE_EN to accept the next instruction during WRITEBACK.
module alu_ctrl_fsm
  import alu_ctrl_pkg::*;
#(
  parameter int NUM_REGS = 16
) (
  input logic          clk,
  input logic          reset,
  alu_ctrl_fsm_if.slave bus
);

  state_t              state;
  logic [15:0]         ir;
  logic                ready_q;
  logic                busy_q;
  logic                buff_en_q;
  logic [NUM_REGS-1:0] enable_q;
  decode_t             dec;
  logic                accept;

  alu_ctrl_decode u_decode (
    .ir  (ir),
    .dec (dec)
  );

  assign accept = bus.instr_valid && ready_q;

  function automatic logic [NUM_REGS-1:0] one_hot(input logic [3:0] idx);
    return NUM_REGS'(1) << idx;
  endfunction

  // NOTE: non-blocking assignments so every register here samples pre-edge values of the others.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      ir        <= '0;
      ready_q   <= 1'b1;
      busy_q    <= 1'b0;
      buff_en_q <= 1'b0;
      enable_q  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            state   <= DECODE;
            ir      <= bus.instr;
            ready_q <= 1'b0;
            busy_q  <= 1'b1;
          end
        end
        DECODE: state <= EXECUTE;
        EXECUTE: begin
          state <= WRITEBACK;
          if (!dec.no_write) begin
            enable_q  <= one_hot(dec.control1[3:0]);
            buff_en_q <= 1'b1;
          end
`ifdef ALU_CTRL_PIPE_EN
          ready_q <= 1'b1;
`endif
        end
        WRITEBACK: begin
          enable_q  <= '0;
          buff_en_q <= 1'b0;
`ifdef ALU_CTRL_PIPE_EN
          if (accept) begin
            state   <= DECODE;
            ir      <= bus.instr;
            ready_q <= 1'b0;
          end else begin
            state  <= IDLE;
            ir     <= '0;
            busy_q <= 1'b0;
          end
`else
          // Clearing the word makes the operand outputs read zero while idle.
          state   <= IDLE;
          ir      <= '0;
          ready_q <= 1'b1;
          busy_q  <= 1'b0;
`endif
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.instr_ready = ready_q;
  assign bus.busy        = busy_q;
  assign bus.enable      = enable_q;
  assign bus.buff_en     = buff_en_q;
  assign bus.illegal     = (state == DECODE) && dec.illegal;
  assign bus.control1    = dec.control1;
  assign bus.control2    = dec.control2;
  assign bus.imm_control = dec.imm_control;
  assign bus.opcode      = dec.opcode;
  assign bus.immediate   = dec.immediate;

endmodule

// File: tb/tb_alu_ctrl_fsm.sv
// Self-checking bench for alu_ctrl_fsm: directed instructions with hand-derived
// expectations queued on drive and compared cycle by cycle against a state model.
module tb_alu_ctrl_fsm;

  localparam int NUM_REGS = 16;
`ifdef ALU_CTRL_PIPE_EN
  localparam bit PIPE = 1'b1;
`else
  localparam bit PIPE = 1'b0;
`endif

  typedef enum logic [1:0] {M_IDLE, M_DEC, M_EXE, M_WB} m_state_t;

  typedef struct {
    logic [15:0] instr;
    logic [4:0]  c1;
    logic [4:0]  c2;
    logic        imm;
    logic [7:0]  opc;
    logic [15:0] immv;
    logic [15:0] en;
    logic        ill;
  } exp_t;

  logic     clk;
  logic     reset;
  int       n_checks = 0;
  int       n_fail   = 0;
  int       acc_count = 0;
  exp_t     q[$];
  exp_t     cur;
  m_state_t m_state;
  logic     m_ready;
  logic     m_acc;

  alu_ctrl_fsm_if #(.NUM_REGS(NUM_REGS)) bus ();

  alu_ctrl_fsm #(.NUM_REGS(NUM_REGS)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Reference timing model of the sequencer.
  assign m_ready = (m_state == M_IDLE) || (PIPE && m_state == M_WB);
  assign m_acc   = bus.instr_valid && m_ready;

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_state <= M_IDLE;
    end else begin
      case (m_state)
        M_DEC: m_state <= M_EXE;
        M_EXE: m_state <= M_WB;
        default: begin
          if (m_acc) begin
            check("scoreboard_nonempty", 32'(q.size() != 0), 32'd1);
            if (q.size() != 0) cur <= q.pop_front();
            m_state   <= M_DEC;
            acc_count <= acc_count + 1;
          end else begin
            m_state <= M_IDLE;
          end
        end
      endcase
    end
  end

  always @(negedge clk) begin
    if (reset === 1'b1) begin
      check("instr_ready", 32'(bus.instr_ready), 32'(m_ready));
      check("busy", 32'(bus.busy), 32'(m_state != M_IDLE));
      check($sformatf("illegal[%h]", cur.instr), 32'(bus.illegal),
            32'(m_state == M_DEC && cur.ill));
      if (m_state != M_IDLE) begin
        check($sformatf("control1[%h]", cur.instr), 32'(bus.control1), 32'(cur.c1));
        check($sformatf("control2[%h]", cur.instr), 32'(bus.control2), 32'(cur.c2));
        if (!cur.ill) begin
          check($sformatf("imm_control[%h]", cur.instr), 32'(bus.imm_control), 32'(cur.imm));
          check($sformatf("opcode[%h]", cur.instr), 32'(bus.opcode), 32'(cur.opc));
          check($sformatf("immediate[%h]", cur.instr), 32'(bus.immediate), 32'(cur.immv));
        end
      end
      check($sformatf("enable[%h]", cur.instr), 32'(bus.enable),
            (m_state == M_WB) ? 32'(cur.en) : 32'd0);
      check($sformatf("buff_en[%h]", cur.instr), 32'(bus.buff_en),
            32'(m_state == M_WB && cur.en != 16'h0));
    end
  end

  task automatic wait_accept();
    int  n;
    bit  got;
    n   = acc_count;
    got = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk);
      #1;
      if (acc_count != n) begin
        got = 1'b1;
        break;
      end
    end
    check("accept_timeout", 32'(got), 32'd1);
  endtask

  task automatic wait_idle();
    bit got;
    got = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (m_state == M_IDLE) begin
        got = 1'b1;
        break;
      end
    end
    check("idle_timeout", 32'(got), 32'd1);
  endtask

  task automatic drive(input logic [15:0] ins, input logic [4:0] c1, input logic [4:0] c2,
                       input logic imm, input logic [7:0] opc, input logic [15:0] immv,
                       input logic [15:0] en, input logic ill);
    exp_t e;
    e.instr = ins; e.c1 = c1; e.c2 = c2; e.imm = imm;
    e.opc = opc; e.immv = immv; e.en = en; e.ill = ill;
    q.push_back(e);
    bus.instr       = ins;
    bus.instr_valid = 1'b1;
    wait_accept();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset           = 1'b0;
    bus.instr       = 16'h0000;
    bus.instr_valid = 1'b0;
    #7;
    check("rst_instr_ready", 32'(bus.instr_ready), 32'd1);
    check("rst_busy",        32'(bus.busy),        32'd0);
    check("rst_enable",      32'(bus.enable),      32'd0);
    check("rst_buff_en",     32'(bus.buff_en),     32'd0);
    check("rst_illegal",     32'(bus.illegal),     32'd0);
    check("rst_control1",    32'(bus.control1),    32'd0);
    check("rst_control2",    32'(bus.control2),    32'd0);
    check("rst_imm_control", 32'(bus.imm_control), 32'd0);
    check("rst_opcode",      32'(bus.opcode),      32'd0);
    check("rst_immediate",   32'(bus.immediate),   32'd0);
    #5 reset = 1'b1;

    // Single instructions, each drained back to idle.
    drive(16'h53FF, 5'd3,  5'd15, 1'b1, 8'h50, 16'hFFFF, 16'h0008, 1'b0); bus.instr_valid = 1'b0; wait_idle();
    drive(16'h1280, 5'd2,  5'd0,  1'b1, 8'h10, 16'h0080, 16'h0004, 1'b0); bus.instr_valid = 1'b0; wait_idle();
    drive(16'h01B4, 5'd1,  5'd4,  1'b0, 8'h0B, 16'h0000, 16'h0000, 1'b0); bus.instr_valid = 1'b0; wait_idle();
    drive(16'hF123, 5'd1,  5'd3,  1'b0, 8'h00, 16'h0000, 16'h0000, 1'b1); bus.instr_valid = 1'b0; wait_idle();
    drive(16'h0A23, 5'd10, 5'd3,  1'b0, 8'h02, 16'h0000, 16'h0400, 1'b0); bus.instr_valid = 1'b0; wait_idle();
    drive(16'h2F7F, 5'd15, 5'd15, 1'b1, 8'h20, 16'h007F, 16'h8000, 1'b0); bus.instr_valid = 1'b0; wait_idle();
    drive(16'h3C80, 5'd12, 5'd0,  1'b1, 8'h30, 16'h0080, 16'h1000, 1'b0); bus.instr_valid = 1'b0; wait_idle();
    drive(16'h9080, 5'd0,  5'd0,  1'b1, 8'h90, 16'hFF80, 16'h0001, 1'b0); bus.instr_valid = 1'b0; wait_idle();
    drive(16'hB57F, 5'd5,  5'd15, 1'b1, 8'hB0, 16'h007F, 16'h0000, 1'b0); bus.instr_valid = 1'b0; wait_idle();
    drive(16'hD6A5, 5'd6,  5'd5,  1'b1, 8'hD0, 16'hFFA5, 16'h0040, 1'b0); bus.instr_valid = 1'b0; wait_idle();
    drive(16'h4123, 5'd1,  5'd3,  1'b0, 8'h00, 16'h0000, 16'h0000, 1'b1); bus.instr_valid = 1'b0; wait_idle();

    // Back-to-back: valid held high across three instructions.
    drive(16'h5111, 5'd1,  5'd1,  1'b1, 8'h50, 16'h0011, 16'h0002, 1'b0);
    drive(16'h0E56, 5'd14, 5'd6,  1'b0, 8'h05, 16'h0000, 16'h4000, 1'b0);
    drive(16'h1733, 5'd7,  5'd3,  1'b1, 8'h10, 16'h0033, 16'h0080, 1'b0);
    bus.instr_valid = 1'b0;
    wait_idle();

    // Valid activity while busy must not be accepted.
    drive(16'h2355, 5'd3,  5'd5,  1'b1, 8'h20, 16'h0055, 16'h0008, 1'b0);
    bus.instr = 16'hFFFF;
    @(posedge clk);
    #1 bus.instr_valid = 1'b0;
    wait_idle();

    // Asynchronous reset in EXECUTE.
    drive(16'h53FF, 5'd3,  5'd15, 1'b1, 8'h50, 16'hFFFF, 16'h0008, 1'b0);
    bus.instr_valid = 1'b0;
    @(posedge clk);
    #2 reset = 1'b0;
    #1;
    check("exe_rst_enable",      32'(bus.enable),      32'd0);
    check("exe_rst_busy",        32'(bus.busy),        32'd0);
    check("exe_rst_instr_ready", 32'(bus.instr_ready), 32'd1);
    #1 reset = 1'b1;

    // Asynchronous reset aborting a write in WRITEBACK.
    drive(16'h1280, 5'd2,  5'd0,  1'b1, 8'h10, 16'h0080, 16'h0004, 1'b0);
    bus.instr_valid = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    check("wb_enable_before_rst", 32'(bus.enable), 32'h0004);
    reset = 1'b0;
    #1;
    check("wb_rst_enable",  32'(bus.enable),  32'd0);
    check("wb_rst_buff_en", 32'(bus.buff_en), 32'd0);
    check("wb_rst_busy",    32'(bus.busy),    32'd0);
    #2 reset = 1'b1;

    // Normal decode after reset recovery.
    drive(16'h5A80, 5'd10, 5'd0,  1'b1, 8'h50, 16'hFF80, 16'h0400, 1'b0); bus.instr_valid = 1'b0; wait_idle();

    repeat (2) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
